sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single SRAM-like memory port between the instruction-fetch requester (IF) and the data requester (EX/ME load/store path) of the five-stage LoongArch pipeline. Accepts at most one transaction at a time and forwards it to the downstream port. Returns the response to its owner. Sits between the pipeline stages and the memory-side bridge; the ME stage consumes its data-side response in place of a raw `data_sram_rdata`.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; byte strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- Instruction requester: `inst_req` in 1, `inst_addr` in ADDR_W, `inst_addr_ok` out 1, `inst_data_ok` out 1, `inst_rdata` out DATA_W. Read-only; implied size 2'b10.
- Data requester: `data_req` in 1, `data_wr` in 1, `data_size` in 2 (0=byte, 1=half, 2=word), `data_wstrb` in DATA_W/8, `data_addr` in ADDR_W, `data_wdata` in DATA_W, `data_addr_ok` out 1, `data_data_ok` out 1, `data_rdata` out DATA_W.
- Memory port: `mem_req` out 1, `mem_wr` out 1, `mem_size` out 2, `mem_wstrb` out DATA_W/8, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_addr_ok` in 1, `mem_data_ok` in 1, `mem_rdata` in DATA_W.
- `busy`  out 1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ADDR, DATA. Registered owner bit `own` (0=inst, 1=data). Request fields are held in registers `r_wr`, `r_size`, `r_wstrb`, `r_addr`, `r_wdata`.
- IDLE:
  - If `data_req`: capture data fields, set `own`=1, pulse `data_addr_ok`=1 this cycle, and go to ADDR.
  - Otherwise, if `inst_req`: capture `inst_addr` with `r_wr`=0, `r_size`=2, `r_wstrb`=0, set `own`=0, pulse `inst_addr_ok`, and go to ADDR.
  - Fixed priority: data over inst.
  - Both addr_ok outputs are 0 outside IDLE. At most one addr_ok is high per cycle.
- ADDR:
  - `mem_req`=1 and `mem_*` are driven from the registers.
  - On `mem_addr_ok`=1, go to DATA.
  - Registers are stable until `mem_addr_ok`.
- DATA:
  - `mem_req`=0.
  - On `mem_data_ok`=1, assert the owner's `*_data_ok`=1 in the same cycle (combinational pass-through). Drive the owner's `*_rdata`=`mem_rdata`, then go to IDLE.
  - The non-owner's data_ok stays 0.
  - A write still completes through data_ok; the rdata value is then don't-care.
- `mem_data_ok` outside DATA is ignored; no response is forwarded.
- `mem_addr_ok` outside ADDR is ignored.
- `inst_rdata`/`data_rdata` equal `mem_rdata` unconditionally. Consumers qualify them with data_ok.
- Requester side: after seeing addr_ok, the requester must drop or change its req. A req still high in the next IDLE is treated as a new transaction.

## Timing
- Reset: state=IDLE, `own`=0, all registers 0. `mem_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok`, `busy` all 0.
- Reset mid-transaction aborts to IDLE. Any later `mem_data_ok` for the aborted access is ignored.
- Minimum transaction, with `mem_addr_ok` and `mem_data_ok` each returned one cycle after being awaited:
  - cycle 0: IDLE, addr_ok to requester.
  - cycle 1: ADDR, `mem_req`=1, `mem_addr_ok`=1.
  - cycle 2: DATA, `mem_data_ok`=1 → requester data_ok.
  - cycle 3: IDLE, next grant possible.
  - Throughput: one transaction per 3 cycles at best.
- Wait cycles are unbounded: the block stays in ADDR or DATA indefinitely with outputs held.
- Simultaneous `inst_req` and `data_req` in IDLE: data wins. Inst waits until the next IDLE in which `data_req`=0. Starvation of inst is permitted by design; the pipeline guarantees `data_req` gaps.

## Test plan
- Reset with `inst_req`=1 and `data_req`=1 held → all outputs 0 during reset. First post-reset cycle: `data_addr_ok`=1, `inst_addr_ok`=0.
- Inst read of 0x1c000000; memory returns 0x02800c0c with `mem_addr_ok` 2 cycles late and `mem_data_ok` 3 cycles late → `mem_addr`=0x1c000000 and `mem_wr`=0 held throughout ADDR. `inst_data_ok`=1 with `inst_rdata`=0x02800c0c for exactly one cycle. `data_data_ok` never asserts.
- Byte store: addr 0x00001003, size 0, wstrb 4'b1000, wdata 0xAB000000 → `mem_wr`=1, `mem_wstrb`=4'b1000, `mem_wdata`=0xAB000000. `data_data_ok` pulses once.
- Simultaneous requests: inst 0x1c000004 and data load 0x00000010 → data served first. Inst granted in the first IDLE after data completes, and never granted while `data_req` is high.
- Spurious `mem_data_ok` and `mem_addr_ok` pulses in IDLE → no data_ok to either requester; state stays IDLE.
- Assert `reset` while in DATA, then pulse `mem_data_ok` → no data_ok; state IDLE. A fresh inst request then completes normally.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the single SRAM-like memory port: data side has fixed priority
// over instruction fetch, one transaction in flight, responses routed back to the owner.
module sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,

    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] INST_SIZE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                own_reg, own_next;
    logic                r_wr_reg, r_wr_next;
    logic [1:0]          r_size_reg, r_size_next;
    logic [STRB_W-1:0]   r_wstrb_reg, r_wstrb_next;
    logic [ADDR_W-1:0]   r_addr_reg, r_addr_next;
    logic [DATA_W-1:0]   r_wdata_reg, r_wdata_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            own_reg     <= 1'b0;
            r_wr_reg    <= 1'b0;
            r_size_reg  <= 2'b00;
            r_wstrb_reg <= '0;
            r_addr_reg  <= '0;
            r_wdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            own_reg     <= own_next;
            r_wr_reg    <= r_wr_next;
            r_size_reg  <= r_size_next;
            r_wstrb_reg <= r_wstrb_next;
            r_addr_reg  <= r_addr_next;
            r_wdata_reg <= r_wdata_next;
        end
    end

    // Handshake outputs are forced low while reset is held so that requesters
    // sitting on req during reset see no grant until the first free cycle.
    always_comb begin
        state_next   = state_reg;
        own_next     = own_reg;
        r_wr_next    = r_wr_reg;
        r_size_next  = r_size_reg;
        r_wstrb_next = r_wstrb_reg;
        r_addr_next  = r_addr_reg;
        r_wdata_next = r_wdata_reg;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        mem_req      = 1'b0;

        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    if (data_req) begin
                        own_next     = 1'b1;
                        r_wr_next    = data_wr;
                        r_size_next  = data_size;
                        r_wstrb_next = data_wstrb;
                        r_addr_next  = data_addr;
                        r_wdata_next = data_wdata;
                        data_addr_ok = 1'b1;
                        state_next   = ADDR;
                    end else if (inst_req) begin
                        own_next     = 1'b0;
                        r_wr_next    = 1'b0;
                        r_size_next  = INST_SIZE;
                        r_wstrb_next = '0;
                        r_addr_next  = inst_addr;
                        r_wdata_next = '0;
                        inst_addr_ok = 1'b1;
                        state_next   = ADDR;
                    end
                end
                ADDR: begin
                    mem_req = 1'b1;
                    if (mem_addr_ok) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (mem_data_ok) begin
                        inst_data_ok = ~own_reg;
                        data_data_ok = own_reg;
                        state_next   = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign mem_wr     = r_wr_reg;
    assign mem_size   = r_size_reg;
    assign mem_wstrb  = r_wstrb_reg;
    assign mem_addr   = r_addr_reg;
    assign mem_wdata  = r_wdata_reg;

    // Read data is a plain pass-through; consumers qualify it with their data_ok.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    assign busy = ~reset & (state_reg != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_sram_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int passed = 0;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge with memory handshakes cleared.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    task automatic clear_reqs();
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_wstrb = '0; data_addr = '0; data_wdata = '0;
    endtask

    task automatic do_reset();
        tick();
        clear_reqs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        tick();
        reset = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h1c000000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h20;
        mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ctl = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy};
            checks++;
            if (ctl !== 6'b0) $display("FAIL reset_outputs cycle %0d: got %b expected 000000", c, ctl);
            else passed++;
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
            $display("FAIL reset_first_grant: got data/inst addr_ok %b expected 10", {data_addr_ok, inst_addr_ok});
        else passed++;
        do_reset();
    endtask

    task automatic test_inst_read();
        tick();
        inst_req = 1'b1; inst_addr = 32'h1c000000;
        @(negedge clk);
        checks++;
        if ({inst_addr_ok, data_addr_ok, busy} !== 3'b100)
            $display("FAIL inst_grant: got inst_ok/data_ok/busy %b expected 100", {inst_addr_ok, data_addr_ok, busy});
        else passed++;
        for (int c = 1; c <= 8; c++) begin
            tick();
            inst_req = 1'b0;
            mem_addr_ok = (c == 3);
            mem_data_ok = (c == 7);
            mem_rdata = (c == 7) ? 32'h02800c0c : 32'hdeadbeef;
            @(negedge clk);
            if (c <= 3) begin
                checks++;
                if ({mem_req, mem_wr, mem_size, mem_addr} !== {1'b1, 1'b0, 2'b10, 32'h1c000000})
                    $display("FAIL inst_addr_phase c%0d: got req=%b wr=%b size=%0d addr=%h expected 1 0 2 1c000000",
                             c, mem_req, mem_wr, mem_size, mem_addr);
                else passed++;
            end else begin
                checks++;
                if (mem_req !== 1'b0) $display("FAIL inst_data_phase_req c%0d: got %b expected 0", c, mem_req);
                else passed++;
            end
            checks++;
            if ({inst_data_ok, data_data_ok, busy} !== {(c == 7), 1'b0, (c <= 7)})
                $display("FAIL inst_resp c%0d: got inst_ok/data_ok/busy %b expected %b",
                         c, {inst_data_ok, data_data_ok, busy}, {(c == 7), 1'b0, (c <= 7)});
            else passed++;
            if (c == 7) begin
                checks++;
                if (inst_rdata !== 32'h02800c0c) $display("FAIL inst_rdata: got %h expected 02800c0c", inst_rdata);
                else passed++;
            end
        end
    endtask

    task automatic test_byte_store();
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b1000;
        data_addr = 32'h00001003; data_wdata = 32'hAB000000;
        @(negedge clk);
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
            $display("FAIL store_grant: got data/inst addr_ok %b expected 10", {data_addr_ok, inst_addr_ok});
        else passed++;
        tick();
        clear_reqs();
        mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !==
            {1'b1, 1'b1, 2'd0, 4'b1000, 32'h00001003, 32'hAB000000})
            $display("FAIL store_fields: got req=%b wr=%b size=%0d wstrb=%b addr=%h wdata=%h expected 1 1 0 1000 00001003 ab000000",
                     mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata);
        else passed++;
        tick();
        mem_data_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b10)
            $display("FAIL store_done: got data/inst data_ok %b expected 10", {data_data_ok, inst_data_ok});
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if ({data_data_ok, busy} !== 2'b00)
            $display("FAIL store_single_pulse: got data_ok/busy %b expected 00", {data_data_ok, busy});
        else passed++;
    endtask

    task automatic test_simultaneous();
        tick();
        inst_req = 1'b1; inst_addr = 32'h1c000004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h10;
        @(negedge clk);
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
            $display("FAIL simul_grant: got data/inst addr_ok %b expected 10", {data_addr_ok, inst_addr_ok});
        else passed++;
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, inst_addr_ok} !== {1'b1, 32'h10, 1'b0})
            $display("FAIL simul_data_addr: got req=%b addr=%h inst_ok=%b expected 1 00000010 0", mem_req, mem_addr, inst_addr_ok);
        else passed++;
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        checks++;
        if ({data_data_ok, inst_data_ok, inst_addr_ok, data_rdata} !== {3'b100, 32'h11111111})
            $display("FAIL simul_data_done: got dok/iok/iaok=%b rdata=%h expected 100 11111111",
                     {data_data_ok, inst_data_ok, inst_addr_ok}, data_rdata);
        else passed++;
        // A second data request in the free cycle still beats the waiting fetch.
        tick();
        data_req = 1'b1; data_addr = 32'h14;
        @(negedge clk);
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
            $display("FAIL simul_regrant: got data/inst addr_ok %b expected 10", {data_addr_ok, inst_addr_ok});
        else passed++;
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h14) $display("FAIL simul_second_addr: got %h expected 00000014", mem_addr);
        else passed++;
        tick();
        mem_data_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (data_data_ok !== 1'b1) $display("FAIL simul_second_done: got %b expected 1", data_data_ok);
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10)
            $display("FAIL simul_inst_grant: got inst/data addr_ok %b expected 10", {inst_addr_ok, data_addr_ok});
        else passed++;
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_wr, mem_addr} !== {2'b10, 32'h1c000004})
            $display("FAIL simul_inst_addr: got req=%b wr=%b addr=%h expected 1 0 1c000004", mem_req, mem_wr, mem_addr);
        else passed++;
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h22222222;
        @(negedge clk);
        checks++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h22222222})
            $display("FAIL simul_inst_done: got iok/dok=%b rdata=%h expected 10 22222222",
                     {inst_data_ok, data_data_ok}, inst_rdata);
        else passed++;
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 4; c++) begin
            tick();
            clear_reqs();
            mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({inst_data_ok, data_data_ok, busy, mem_req} !== 4'b0)
                $display("FAIL spurious c%0d: got iok/dok/busy/req %b expected 0000", c,
                         {inst_data_ok, data_data_ok, busy, mem_req});
            else passed++;
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL spurious_idle: got busy %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_reset_abort();
        tick();
        inst_req = 1'b1; inst_addr = 32'h1c000008;
        @(negedge clk);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if ({busy, mem_req} !== 2'b10) $display("FAIL abort_in_data: got busy/req %b expected 10", {busy, mem_req});
        else passed++;
        tick();
        reset = 1'b1;
        @(negedge clk);
        tick();
        reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        checks++;
        if ({inst_data_ok, data_data_ok, busy} !== 3'b000)
            $display("FAIL abort_late_data: got iok/dok/busy %b expected 000", {inst_data_ok, data_data_ok, busy});
        else passed++;
        tick();
        inst_req = 1'b1; inst_addr = 32'h1c00000c;
        @(negedge clk);
        checks++;
        if (inst_addr_ok !== 1'b1) $display("FAIL abort_fresh_grant: got %b expected 1", inst_addr_ok);
        else passed++;
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h1c00000c})
            $display("FAIL abort_fresh_addr: got req=%b addr=%h expected 1 1c00000c", mem_req, mem_addr);
        else passed++;
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h33333333;
        @(negedge clk);
        checks++;
        if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h33333333})
            $display("FAIL abort_fresh_done: got ok=%b rdata=%h expected 1 33333333", inst_data_ok, inst_rdata);
        else passed++;
    endtask

    typedef struct {
        bit        own;
        bit        wr;
        bit [1:0]  size;
        bit [3:0]  wstrb;
        bit [31:0] addr;
        bit [31:0] wdata;
    } txn_t;

    // Model: at most one accepted transaction; it is first offered to memory,
    // then awaits its response. Grants happen only when nothing is in flight.
    task automatic test_random();
        txn_t cur;
        bit   have = 1'b0;
        bit   accepted = 1'b0;
        bit   e_iaok, e_daok, e_iok, e_dok;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            data_req   = ($urandom_range(0, 9) < 4);
            data_wr    = $urandom_range(0, 1);
            data_size  = 2'($urandom_range(0, 2));
            data_wstrb = 4'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
            inst_req   = ($urandom_range(0, 1) == 1);
            inst_addr  = $urandom;
            mem_addr_ok = $urandom_range(0, 1);
            mem_data_ok = (have && accepted) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
            mem_rdata  = $urandom;
            @(negedge clk);
            e_daok = !have && data_req;
            e_iaok = !have && !data_req && inst_req;
            e_iok  = have && accepted && mem_data_ok && !cur.own;
            e_dok  = have && accepted && mem_data_ok && cur.own;
            checks++;
            if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, mem_req} !==
                {e_iaok, e_daok, e_iok, e_dok, have, have && !accepted})
                $display("FAIL rand_ctl c%0d: got iaok/daok/iok/dok/busy/req %b expected %b", c,
                         {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, mem_req},
                         {e_iaok, e_daok, e_iok, e_dok, have, have && !accepted});
            else passed++;
            if (have && !accepted) begin
                checks++;
                if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !==
                    {cur.wr, cur.size, cur.wstrb, cur.addr, cur.wdata})
                    $display("FAIL rand_fields c%0d: got wr=%b size=%0d wstrb=%b addr=%h wdata=%h expected %b %0d %b %h %h",
                             c, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
                             cur.wr, cur.size, cur.wstrb, cur.addr, cur.wdata);
                else passed++;
            end
            checks++;
            if ({inst_rdata, data_rdata} !== {mem_rdata, mem_rdata})
                $display("FAIL rand_rdata c%0d: got %h/%h expected %h", c, inst_rdata, data_rdata, mem_rdata);
            else passed++;
            if (have && accepted && mem_data_ok) begin
                have = 1'b0;
            end else if (have && !accepted && mem_addr_ok) begin
                accepted = 1'b1;
            end else if (!have && data_req) begin
                cur = '{1'b1, data_wr, data_size, data_wstrb, data_addr, data_wdata};
                have = 1'b1; accepted = 1'b0;
            end else if (!have && inst_req) begin
                cur = '{1'b0, 1'b0, 2'd2, 4'd0, inst_addr, 32'd0};
                have = 1'b1; accepted = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_reqs();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_inst_read();
        test_byte_store();
        test_simultaneous();
        test_spurious();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
